// File: rtl/wr_arbiter.sv
// Round-robin write-port arbiter: grants one producer per burst onto the FIFO
// write port, holds the grant until the last beat is accepted, and never writes into a full FIFO.
module wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          wr_clk,
  input  logic                          wr_rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic                          full,
  output logic                          wr_en,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [ID_WIDTH-1:0]           grant_id,
  output logic                          busy
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;

  logic [0:0]          state;
  logic [0:0]          state_next;
  logic [ID_WIDTH-1:0] last_grant;
  logic [ID_WIDTH-1:0] pick_id;
  logic                pick_found;
  logic [15:0]         beat_cnt;

  // Scan starts just after the previous winner so every producer gets a turn.
  always_comb begin
    pick_found = 1'b0;
    pick_id    = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!pick_found && req_valid[ID_WIDTH'((int'(last_grant) + i) % NUM_REQ)]) begin
        pick_found = 1'b1;
        pick_id    = ID_WIDTH'((int'(last_grant) + i) % NUM_REQ);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == ST_BURST && !full && !wr_rst) begin
      req_ready[grant_id] = 1'b1;
    end
  end

  assign wr_en   = req_valid[grant_id] & req_ready[grant_id];
  assign wr_data = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_next = ST_BURST;
        end
      end
      ST_BURST: begin
        if (wr_en && req_last[grant_id]) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // last_grant resets to the top index so producer 0 wins the first contest.
  always_ff @(posedge wr_clk) begin
    if (wr_rst) begin
      state      <= ST_IDLE;
      grant_id   <= '0;
      last_grant <= ID_WIDTH'(NUM_REQ - 1);
      busy       <= 1'b0;
      beat_cnt   <= 16'd0;
    end else begin
      state <= state_next;
      busy  <= (state_next == ST_BURST);
      if (state == ST_IDLE && pick_found) begin
        grant_id   <= pick_id;
        last_grant <= pick_id;
      end
      if (wr_en) begin
        beat_cnt <= beat_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_wr_arbiter.sv
// Self-checking bench for wr_arbiter: directed scenarios, a randomized phase and a
// beat-counter wrap run, all checked against a rule-level model of the arbiter.
module tb_wr_arbiter;

   localparam int N  = 4;
   localparam int DW = 8;
   localparam int IW = 2;

   logic            wr_clk;
   logic            wr_rst;
   logic [N-1:0]    req_valid;
   logic [N-1:0]    req_last;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]    req_ready;
   logic            full;
   logic            wr_en;
   logic [DW-1:0]   wr_data;
   logic [IW-1:0]   grant_id;
   logic            busy;

   int checks   = 0;
   int failures = 0;

   // Producer-side state: beats left in the burst, whether a beat is on offer, and its data.
   int            rem[N];
   bit            pres[N];
   bit            hold[N];
   logic [DW-1:0] dat[N];
   bit            rst_q;
   bit            full_q;
   bit            auto_single;
   bit            rand_mode;

   // Reference model of the arbiter at the level of its rules.
   bit            m_busy;
   logic [IW-1:0] m_owner;
   logic [IW-1:0] m_last;
   int            m_cnt;

   wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
      .wr_clk   (wr_clk),
      .wr_rst   (wr_rst),
      .req_valid(req_valid),
      .req_last (req_last),
      .req_data (req_data),
      .req_ready(req_ready),
      .full     (full),
      .wr_en    (wr_en),
      .wr_data  (wr_data),
      .grant_id (grant_id),
      .busy     (busy)
   );

   // Free-running write clock, 10 time units per period.
   initial begin
      wr_clk = 1'b0;
      forever #5 wr_clk = ~wr_clk;
   end

   // One comparison: counts it and reports any disagreement.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // One clock cycle: drive producers, check combinational outputs, advance the model,
   // cross the edge, check registered outputs, then let producers react to acceptance.
   task automatic applyStimulus();
      logic [N-1:0] exp_ready;
      bit           exp_wr;
      bit           found;
      int           acc;
      int           c;
      if (rand_mode) begin
         full_q = ($urandom_range(0, 4) == 0);
         rst_q  = ($urandom_range(0, 99) == 0);
         for (int p = 0; p < N; p++) begin
            if (rem[p] == 0 && $urandom_range(0, 3) == 0) rem[p] = int'($urandom_range(1, 4));
            if (rem[p] > 0 && !pres[p] && $urandom_range(0, 2) != 0) pres[p] = 1'b1;
         end
      end
      for (int p = 0; p < N; p++) begin
         req_valid[IW'(p)]     = pres[p] && !hold[p];
         req_last[IW'(p)]      = (rem[p] == 1);
         req_data[p*DW +: DW]  = dat[p];
      end
      full   = full_q;
      wr_rst = rst_q;
      #2;
      exp_ready = '0;
      if (m_busy && !full_q && !rst_q) exp_ready[m_owner] = 1'b1;
      exp_wr = m_busy && req_valid[m_owner] && exp_ready[m_owner];
      checkOutput("req_ready", 32'(req_ready), 32'(exp_ready));
      checkOutput("wr_en", 32'(wr_en), 32'(exp_wr));
      if (exp_wr) checkOutput("wr_data", 32'(wr_data), 32'(dat[m_owner]));
      acc = -1;
      if (rst_q) begin
         m_busy  = 1'b0;
         m_owner = '0;
         m_last  = IW'(N - 1);
         m_cnt   = 0;
      end else if (!m_busy) begin
         found = 1'b0;
         c     = int'(m_last);
         repeat (N) begin
            c = (c == N - 1) ? 0 : c + 1;
            if (!found && req_valid[IW'(c)]) begin
               found   = 1'b1;
               m_owner = IW'(c);
               m_last  = IW'(c);
            end
         end
         if (found) m_busy = 1'b1;
      end else if (exp_wr) begin
         m_cnt = (m_cnt + 1) % 65536;
         acc   = int'(m_owner);
         if (req_last[m_owner]) m_busy = 1'b0;
      end
      @(posedge wr_clk);
      #1;
      checkOutput("grant_id", 32'(grant_id), 32'(m_owner));
      checkOutput("busy", 32'(busy), 32'(m_busy));
      checkOutput("beat_cnt", 32'(dut.beat_cnt), m_cnt);
      if (acc >= 0) begin
         rem[acc]--;
         dat[acc]  = rand_mode ? 8'($urandom) : 8'(dat[acc] + 8'd1);
         pres[acc] = rand_mode ? 1'b0 : (rem[acc] > 0);
         if (auto_single && rem[acc] == 0) begin
            rem[acc]  = 1;
            pres[acc] = 1'b1;
         end
      end
   endtask

   task automatic startBurst(input int p, input int len, input logic [DW-1:0] d);
      rem[p]  = len;
      pres[p] = 1'b1;
      dat[p]  = d;
   endtask

   // Bounded wait until producer p has `target` beats left.
   task automatic stepUntilRem(input int p, input int target, input int bound);
      int n = 0;
      while (rem[p] > target && n < bound) begin
         applyStimulus();
         n++;
      end
      checkOutput($sformatf("wait_rem_p%0d", p), 32'(rem[p]), 32'(target));
   endtask

   // Finish every outstanding burst with the FIFO open, bounded.
   task automatic drainAll();
      int n = 0;
      int total;
      rand_mode   = 1'b0;
      auto_single = 1'b0;
      full_q      = 1'b0;
      rst_q       = 1'b0;
      for (int p = 0; p < N; p++) begin
         hold[p] = 1'b0;
         pres[p] = (rem[p] > 0);
      end
      total = rem[0] + rem[1] + rem[2] + rem[3];
      while (total > 0 && n < 400) begin
         applyStimulus();
         total = rem[0] + rem[1] + rem[2] + rem[3];
         n++;
      end
      checkOutput("drain_done", 32'(total), 32'd0);
   endtask

   // Linear sequence of directed scenarios, a random phase, then the counter wrap.
   initial begin
      int len;
      for (int p = 0; p < N; p++) begin
         rem[p]  = 0;
         pres[p] = 1'b0;
         hold[p] = 1'b0;
         dat[p]  = 8'($urandom);
      end
      rand_mode   = 1'b0;
      auto_single = 1'b0;
      full_q      = 1'b0;
      rst_q       = 1'b1;
      m_busy      = 1'b0;
      m_owner     = '0;
      m_last      = IW'(N - 1);
      m_cnt       = 0;
      req_valid   = '0;
      req_last    = '0;
      req_data    = '0;
      full        = 1'b0;
      wr_rst      = 1'b1;
      @(posedge wr_clk);
      #1;
      $display("[TB] reset");
      applyStimulus();
      applyStimulus();
      rst_q = 1'b0;

      $display("[TB] producer 2 three-beat burst");
      startBurst(2, 3, 8'hA0);
      applyStimulus();
      checkOutput("first_grant", 32'(grant_id), 32'd2);
      repeat (3) applyStimulus();
      checkOutput("burst_end_busy", 32'(busy), 32'd0);
      checkOutput("burst_end_cnt", 32'(dut.beat_cnt), 32'd3);

      $display("[TB] all producers single-beat");
      auto_single = 1'b1;
      for (int p = 0; p < N; p++) startBurst(p, 1, 8'(8'h40 + 8'(p * 16)));
      repeat (12) applyStimulus();
      drainAll();

      $display("[TB] full stall mid-burst");
      startBurst(1, 4, 8'h10);
      applyStimulus();
      startBurst(2, 1, 8'h20);
      stepUntilRem(1, 2, 10);
      full_q = 1'b1;
      repeat (5) applyStimulus();
      checkOutput("full_hold_grant", 32'(grant_id), 32'd1);
      full_q = 1'b0;
      drainAll();

      $display("[TB] owner drops valid mid-burst");
      startBurst(0, 4, 8'h30);
      applyStimulus();
      startBurst(3, 1, 8'h50);
      stepUntilRem(0, 3, 10);
      hold[0] = 1'b1;
      repeat (2) applyStimulus();
      checkOutput("gap_hold_grant", 32'(grant_id), 32'd0);
      hold[0] = 1'b0;
      stepUntilRem(0, 0, 20);
      applyStimulus();
      checkOutput("p3_after_p0", 32'(grant_id), 32'd3);
      drainAll();

      $display("[TB] reset mid-burst");
      startBurst(1, 4, 8'h60);
      applyStimulus();
      stepUntilRem(1, 3, 10);
      rst_q = 1'b1;
      applyStimulus();
      rst_q = 1'b0;
      checkOutput("rst_cnt", 32'(dut.beat_cnt), 32'd0);
      startBurst(2, 2, 8'h70);
      applyStimulus();
      checkOutput("rst_regrant", 32'(grant_id), 32'd1);
      drainAll();

      $display("[TB] randomized traffic");
      rand_mode = 1'b1;
      repeat (800) applyStimulus();
      drainAll();

      $display("[TB] beat counter wrap");
      len = (m_cnt == 0) ? 65536 : 65536 - m_cnt;
      startBurst(0, len, 8'h00);
      stepUntilRem(0, 0, 70000);
      applyStimulus();
      checkOutput("wrap_cnt", 32'(dut.beat_cnt), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/wr_arbiter.md
# wr_arbiter

Write-side arbiter that shares the asynchronous FIFO's single write port among `NUM_REQ` producers in the write clock domain. Each producer offers bursts of beats terminated by a `last` flag. The arbiter grants one producer per burst in round-robin order and holds the grant until that burst's last beat is accepted. It drives the FIFO's `wr_en`/data and honours the FIFO `full` flag, so no write is ever issued into a full FIFO.

## Interface
- `NUM_REQ`, 4: number of producers, ≥2.
- `DATA_WIDTH`, 8: FIFO data width.
- `ID_WIDTH`, `$clog2(NUM_REQ)`: width of the grant index.

- `wr_clk`  in  1  write-domain clock; all logic on rising edge.
- `wr_rst`  in  1  reset, synchronous, active-high.
- `req_valid`  in  NUM_REQ  per-producer beat valid.
- `req_last`  in  NUM_REQ  per-producer last-beat flag, qualified by `req_valid`.
- `req_data`  in  NUM_REQ*DATA_WIDTH  per-producer data; producer i occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_ready`  out  NUM_REQ  per-producer beat accepted this cycle when high together with `req_valid`.
- `full`  in  1  FIFO full flag, registered in `wr_clk` domain.
- `wr_en`  out  1  FIFO write enable.
- `wr_data`  out  DATA_WIDTH  FIFO write data.
- `grant_id`  out  ID_WIDTH  index of current or most recent owner.
- `busy`  out  1  high while a burst is in progress (state BURST).

## Operation
- FSM, 2 states:
  - IDLE: no owner. If any `req_valid` is high, select the first valid producer scanning from `last_grant+1` upward, modulo `NUM_REQ`. Register it into `grant_id`/`last_grant` and go to BURST.
  - BURST: owner is `grant_id`. Leave to IDLE on the cycle a beat with `req_last[grant_id]` is accepted.
- Beat acceptance is combinational in BURST:
  - `req_ready[grant_id] = ~full & ~wr_rst`.
  - All other `req_ready` bits are 0.
  - `wr_en = req_valid[grant_id] & req_ready[grant_id]`.
  - `wr_data = req_data[grant_id]`.
- In IDLE: `wr_en = 0` and all `req_ready = 0`.
- Producers must hold valid/data/last stable until accepted. Deasserting `req_valid` mid-burst is legal: the grant is held and nothing is written until valid returns.
- `full` high in BURST: `req_ready` and `wr_en` are 0, and the state and owner are held. Transfer resumes the cycle `full` drops.
- Beat counter `beat_cnt` (16 bit, internal, visible to the bench) increments on each `wr_en`, wraps from 0xFFFF to 0, and is cleared only by reset.
- Round-robin pointer `last_grant` updates only on the IDLE→BURST transition.
- Fairness: a producer that holds `req_valid` continuously is granted within `NUM_REQ-1` bursts.
- A single-beat burst (valid and last together) is a legal burst.

## Timing
- Reset values on the first edge with `wr_rst` high:
  - state IDLE, `grant_id = 0`, `last_grant = NUM_REQ-1` (producer 0 wins the first tie), `busy = 0`, `beat_cnt = 0`.
  - `wr_en = 0` and `req_ready = 0`, combinationally forced while `wr_rst` is high.
- Reset mid-burst: the burst is abandoned, no beat is written in the reset cycle, and arbitration restarts from producer 0.
- Arbitration latency is 1 cycle: `req_valid` is seen in IDLE at edge N, BURST with the grant at N+1, and the first beat can be accepted in the cycle after edge N+1.
- Throughput is 1 beat per cycle during a burst when `full` is low.
- Each burst costs 1 idle cycle (the IDLE arbitration cycle) between the last beat and the next burst's first beat, including back-to-back bursts from the same producer.
- `busy` is a registered copy of the state, equal to (state == BURST).
- `full` rising in the same cycle as a last beat: the beat is not accepted and the state stays BURST.

## Test plan
- Reset, then producer 2 alone sends a 3-beat burst A0, A1, A2(last) with `full = 0`:
  - `grant_id = 2` one cycle after valid; `wr_en` high for 3 consecutive cycles with data A0..A2.
  - `busy` returns low after A2; `beat_cnt = 3`.
- All 4 producers continuously valid with 1-beat bursts:
  - Grant order 0,1,2,3,0.
  - `wr_en` pattern is 0,1 repeating.
- Producer 1 in a 4-beat burst, `full` forced high for 5 cycles after beat 2:
  - `wr_en = 0` and `req_ready[1] = 0` for those 5 cycles; `grant_id` holds 1.
  - Beats 3–4 are written immediately after `full` drops; no other producer is granted.
- Producer 0 mid-burst, producer 3 valid:
  - Producer 0 drops `req_valid` for 2 cycles: no write, grant held.
  - Producer 3 is granted only after producer 0's last beat.
- `wr_rst` pulsed for 1 cycle during producer 1's burst beat 2:
  - `wr_en = 0` in the reset cycle; state IDLE; `beat_cnt = 0`.
  - Next arbitration with producers 1 and 2 valid grants producer 1 (scan starts at 0, so 1 wins).
- Beat-count wrap: preload via 65536 single-beat writes -> `beat_cnt` reads 0 after the 65536th `wr_en`.
